// File: rtl/fetch_stall_pipe_pkg.sv
// Shared fetch/decode definitions: reset PC, NOP word, control-bundle layout and IF/ID payload.
package fetch_stall_pipe_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned CTRL_W_DEFAULT = 9;

    localparam logic [XLEN-1:0] PC_RESET_DEFAULT  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    // Bit offsets inside the decoded control bundle, common to decoder and hazard unit
    localparam int unsigned CTRL_REGWRITE = 0;
    localparam int unsigned CTRL_MEMREAD  = 1;
    localparam int unsigned CTRL_MEMWRITE = 2;
    localparam int unsigned CTRL_MEMTOREG = 3;
    localparam int unsigned CTRL_ALUSRC   = 4;
    localparam int unsigned CTRL_BRANCH   = 5;
    localparam int unsigned CTRL_ALUOP_LO = 6;
    localparam int unsigned CTRL_ALUOP_HI = 7;
    localparam int unsigned CTRL_JUMP     = 8;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc4;
        logic            valid;
    } ifid_t;

    localparam int unsigned IFID_W = $bits(ifid_t);

    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/fetch_stall_pipe_pipe_reg_en.sv
// Pipeline register with synchronous reset, flush-value load and hold enable.
module pipe_reg_en #(
    parameter int unsigned  W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         flush,
    input  logic [W-1:0] d,
    input  logic [W-1:0] flush_val,
    output logic [W-1:0] q
);

    // Priority: reset, then flush, then enabled load
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (flush) begin
            q <= flush_val;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stall_pipe.sv
// PC, IF/ID and ID/EX control registers driven by hazard-unit stall commands and branch redirect.
// Optional FETCH_PERF_EN adds saturating stall_cycles / bubble_cycles counters.
module fetch_stall_pipe
    import fetch_stall_pipe_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = PC_RESET_DEFAULT,
    parameter int unsigned CTRL_W    = CTRL_W_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PCwrite,
    input  logic              IFIDwrite,
    input  logic              Ctrl_IDEX_mux,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    output logic [31:0]       imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       ifid_instr,
    output logic [31:0]       ifid_pc4,
    output logic              ifid_valid,
    input  logic [CTRL_W-1:0] ctrl_in,
    output logic [CTRL_W-1:0] idex_ctrl,
    output logic              idex_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       bubble_cycles
`endif
);

    localparam int unsigned IDEX_W   = CTRL_W + 1;
    localparam ifid_t       IFID_RST = '{instr: NOP_INSTR, pc4: '0, valid: 1'b0};

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4;
    ifid_t       ifid_d;
    ifid_t       ifid_q;
    logic [IDEX_W-1:0] idex_d;
    logic [IDEX_W-1:0] idex_q;

    assign pc_plus4 = pc_inc(pc_q);

    // Branch redirect overrides the PC hold
    always_comb begin
        pc_d = pc_q;
        if (branch_taken) begin
            pc_d = branch_target;
        end else if (PCwrite) begin
            pc_d = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign imem_addr = pc_q;

    assign ifid_d = '{instr: imem_rdata, pc4: pc_plus4, valid: 1'b1};

    pipe_reg_en #(
        .W       (IFID_W),
        .RST_VAL (IFID_RST)
    ) u_ifid (
        .clk       (clk),
        .rst       (rst),
        .en        (IFIDwrite),
        .flush     (branch_taken),
        .d         (ifid_d),
        .flush_val (IFID_RST),
        .q         (ifid_q)
    );

    assign ifid_instr = ifid_q.instr;
    assign ifid_pc4   = ifid_q.pc4;
    assign ifid_valid = ifid_q.valid;

    // ID/EX always loads; a bubble is a flush to all-zero control
    assign idex_d = {ctrl_in, ifid_q.valid};

    pipe_reg_en #(
        .W       (IDEX_W),
        .RST_VAL ('0)
    ) u_idex (
        .clk       (clk),
        .rst       (rst),
        .en        (1'b1),
        .flush     (!Ctrl_IDEX_mux),
        .d         (idex_d),
        .flush_val ({IDEX_W{1'b0}}),
        .q         (idex_q)
    );

    assign idex_ctrl  = idex_q[IDEX_W-1:1];
    assign idex_valid = idex_q[0];

`ifdef FETCH_PERF_EN
    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles  <= '0;
            bubble_cycles <= '0;
        end else begin
            if (!PCwrite && !branch_taken && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (!Ctrl_IDEX_mux && (bubble_cycles != 32'hFFFF_FFFF)) begin
                bubble_cycles <= bubble_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stall_pipe.sv
// Bench for fetch_stall_pipe: directed vector table, hand sequences, randomized run vs reference model.
module tb_fetch_stall_pipe;

    localparam logic [31:0] PC_RST = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam int unsigned CW     = 9;

    logic          clk;
    logic          rst;
    logic          PCwrite;
    logic          IFIDwrite;
    logic          Ctrl_IDEX_mux;
    logic          branch_taken;
    logic [31:0]   branch_target;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_rdata;
    logic [31:0]   ifid_instr;
    logic [31:0]   ifid_pc4;
    logic          ifid_valid;
    logic [CW-1:0] ctrl_in;
    logic [CW-1:0] idex_ctrl;
    logic          idex_valid;
`ifdef FETCH_PERF_EN
    logic [31:0]   stall_cycles;
    logic [31:0]   bubble_cycles;
`endif

    fetch_stall_pipe #(
        .PC_RESET  (PC_RST),
        .CTRL_W    (CW),
        .NOP_INSTR (NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .PCwrite       (PCwrite),
        .IFIDwrite     (IFIDwrite),
        .Ctrl_IDEX_mux (Ctrl_IDEX_mux),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .ifid_instr    (ifid_instr),
        .ifid_pc4      (ifid_pc4),
        .ifid_valid    (ifid_valid),
        .ctrl_in       (ctrl_in),
        .idex_ctrl     (idex_ctrl),
        .idex_valid    (idex_valid)
`ifdef FETCH_PERF_EN
        ,
        .stall_cycles  (stall_cycles),
        .bubble_cycles (bubble_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst, pw, iw, cm, bt;
        logic [31:0]   tgt;
        logic [31:0]   rdata;
        logic [CW-1:0] ci;
        logic [31:0]   e_addr;
        logic [31:0]   e_instr;
        logic [31:0]   e_pc4;
        logic          e_ifv;
        logic          e_idv;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    // Reference state: what the pipeline should hold after each edge
    logic [31:0]   m_pc;
    logic [31:0]   m_instr;
    logic [31:0]   m_pc4;
    logic          m_ifv;
    logic [CW-1:0] m_ctrl;
    logic          m_idv;
    longint        m_stall;
    longint        m_bubble;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, pw, iw, cm, bt, input logic [31:0] tgt, rdata,
                                input logic [31:0] ea, ei, ep, input logic ev, ed);
        vec_t v;
        v.rst = r; v.pw = pw; v.iw = iw; v.cm = cm; v.bt = bt;
        v.tgt = tgt; v.rdata = rdata; v.ci = CW'(rdata[8:0] ^ 9'h15A);
        v.e_addr = ea; v.e_instr = ei; v.e_pc4 = ep; v.e_ifv = ev; v.e_idv = ed;
        return v;
    endfunction

    // Apply one cycle of inputs, advance the model by the operating rules, compare all outputs
    task automatic cycle(input vec_t v);
        logic [31:0] sat;
        rst = v.rst; PCwrite = v.pw; IFIDwrite = v.iw; Ctrl_IDEX_mux = v.cm;
        branch_taken = v.bt; branch_target = v.tgt; imem_rdata = v.rdata; ctrl_in = v.ci;
        if (v.rst) begin
            m_pc = PC_RST; m_instr = NOP; m_pc4 = 0; m_ifv = 0; m_ctrl = 0; m_idv = 0;
            m_stall = 0; m_bubble = 0;
        end else begin
            if (v.cm) begin
                m_ctrl = v.ci; m_idv = m_ifv;
            end else begin
                m_ctrl = 0; m_idv = 0;
            end
            if (v.bt) begin
                m_instr = NOP; m_pc4 = 0; m_ifv = 0;
            end else if (v.iw) begin
                m_instr = v.rdata; m_pc4 = m_pc + 32'd4; m_ifv = 1;
            end
            if (v.bt)      m_pc = v.tgt;
            else if (v.pw) m_pc = m_pc + 32'd4;
            if (!v.pw && !v.bt) m_stall++;
            if (!v.cm) m_bubble++;
        end
        @(posedge clk);
        #1;
        chk("imem_addr", imem_addr, m_pc);
        chk("ifid_instr", ifid_instr, m_instr);
        chk("ifid_pc4", ifid_pc4, m_pc4);
        chk("ifid_valid", 32'(ifid_valid), 32'(m_ifv));
        chk("idex_ctrl", 32'(idex_ctrl), 32'(m_ctrl));
        chk("idex_valid", 32'(idex_valid), 32'(m_idv));
`ifdef FETCH_PERF_EN
        sat = (m_stall > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_stall[31:0];
        chk("stall_cycles", stall_cycles, sat);
        sat = (m_bubble > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_bubble[31:0];
        chk("bubble_cycles", bubble_cycles, sat);
`else
        sat = 32'h0;
        if (sat != 32'h0) $display("unreachable");
`endif
    endtask

    vec_t vecs[11];
    vec_t rv;

    initial begin
        rst = 1; PCwrite = 1; IFIDwrite = 1; Ctrl_IDEX_mux = 1; branch_taken = 0;
        branch_target = 0; imem_rdata = 0; ctrl_in = 0;
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_ifv = 0; m_ctrl = 0; m_idv = 0;
        m_stall = 0; m_bubble = 0;

        //          rst pw iw cm bt  tgt        rdata         addr       instr         pc4        ifv idv
        vecs[0]  = mk(1, 1, 1, 1, 0, 32'h0,     32'h0,        32'h0,     NOP,          32'h0,     0, 0);
        vecs[1]  = mk(0, 1, 1, 1, 0, 32'h0,     32'hA000_0000, 32'h4,    32'hA000_0000, 32'h4,    1, 0);
        vecs[2]  = mk(0, 1, 1, 1, 0, 32'h0,     32'hA000_0004, 32'h8,    32'hA000_0004, 32'h8,    1, 1);
        vecs[3]  = mk(0, 0, 0, 0, 0, 32'h0,     32'hDEAD_0008, 32'h8,    32'hA000_0004, 32'h8,    1, 0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 32'h0,     32'hBEEF_0008, 32'h8,    32'hA000_0004, 32'h8,    1, 0);
        vecs[5]  = mk(0, 1, 1, 1, 0, 32'h0,     32'hA000_0008, 32'hC,    32'hA000_0008, 32'hC,    1, 1);
        vecs[6]  = mk(0, 0, 1, 1, 1, 32'h100,   32'hA000_000C, 32'h100,  NOP,          32'h0,     0, 1);
        vecs[7]  = mk(0, 1, 1, 1, 0, 32'h0,     32'hA000_0100, 32'h104,  32'hA000_0100, 32'h104,  1, 0);
        vecs[8]  = mk(0, 0, 0, 1, 0, 32'h0,     32'h1234_5678, 32'h104,  32'hA000_0100, 32'h104,  1, 1);
        vecs[9]  = mk(1, 0, 0, 1, 0, 32'h0,     32'h1234_5678, PC_RST,   NOP,          32'h0,     0, 0);
        vecs[10] = mk(0, 1, 1, 1, 0, 32'h0,     32'hA000_0000, 32'h4,    32'hA000_0000, 32'h4,    1, 0);

        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            cycle(vecs[i]);
            chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d_instr", i), ifid_instr, vecs[i].e_instr);
            chk($sformatf("vec%0d_pc4", i), ifid_pc4, vecs[i].e_pc4);
            chk($sformatf("vec%0d_ifv", i), 32'(ifid_valid), 32'(vecs[i].e_ifv));
            chk($sformatf("vec%0d_idv", i), 32'(idex_valid), 32'(vecs[i].e_idv));
        end

        // PC wrap: redirect to the last word, then advance past it
        cycle(mk(0, 1, 1, 1, 1, 32'hFFFF_FFFC, 32'h0, 0, 0, 0, 0, 0));
        chk("wrap_pre_addr", imem_addr, 32'hFFFF_FFFC);
        cycle(mk(0, 1, 1, 1, 0, 32'h0, 32'hCAFE_F00D, 0, 0, 0, 0, 0));
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_pc4", ifid_pc4, 32'h0);
        chk("wrap_instr", ifid_instr, 32'hCAFE_F00D);

        // Unaligned target: low bits carried through
        cycle(mk(0, 1, 1, 1, 1, 32'h0000_0203, 32'h0, 0, 0, 0, 0, 0));
        cycle(mk(0, 1, 1, 1, 0, 32'h0, 32'h7, 0, 0, 0, 0, 0));
        chk("unaligned_addr", imem_addr, 32'h0000_0207);
        chk("unaligned_pc4", ifid_pc4, 32'h0000_0207);

`ifdef FETCH_PERF_EN
        cycle(mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) cycle(mk(0, 0, 0, 1, 0, 0, 32'h11, 0, 0, 0, 0, 0));
        for (int i = 0; i < 2; i++) cycle(mk(0, 1, 1, 0, 0, 0, 32'h22, 0, 0, 0, 0, 0));
        cycle(mk(0, 0, 1, 1, 1, 32'h40, 32'h33, 0, 0, 0, 0, 0));
        chk("perf_stall", stall_cycles, 32'd3);
        chk("perf_bubble", bubble_cycles, 32'd2);
`endif

        // Randomized run against the reference model
        for (int i = 0; i < 400; i++) begin
            rv.rst   = ($urandom_range(0, 49) == 0);
            rv.pw    = ($urandom_range(0, 3) != 0);
            rv.iw    = ($urandom_range(0, 3) != 0);
            rv.cm    = ($urandom_range(0, 3) != 0);
            rv.bt    = ($urandom_range(0, 7) == 0);
            rv.tgt   = $urandom;
            rv.rdata = $urandom;
            rv.ci    = CW'($urandom);
            cycle(rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
